// File: rtl/classifier_frame_scheduler.sv
// rtl/classifier_frame_scheduler.sv - ping-pong frame banks feeding the classifier and frame-ID tagging of its results; CLS_LATENCY_STATS_EN enables release-to-result latency stamping
module classifier_frame_scheduler #(
   parameter int PIXELS_PER_FRAME = 784,
   parameter int ADDR_W           = 10,
   parameter int ID_W             = 8,
   parameter int TAG_DEPTH        = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [7:0]        pix_data,
   input  logic              pix_valid,
   output logic              pix_ready,
   input  logic              cls_input_valid_write_en,
   input  logic [7:0]        cls_input_valid_write_data,
   output logic [7:0]        cls_input_valid_read_data,
   input  logic [ADDR_W-1:0] cls_input_address_a,
   output logic [15:0]       cls_input_read_data_a,
   input  logic [3:0]        cls_output_data,
   input  logic              cls_output_valid,
   output logic              cls_output_ready,
   output logic [3:0]        res_digit,
   output logic [ID_W-1:0]   res_frame_id,
   output logic [15:0]       res_latency,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [15:0]       frames_done,
   output logic              tag_underflow
);

   localparam int CNT_W = (PIXELS_PER_FRAME > 1) ? $clog2(PIXELS_PER_FRAME) : 1;
   localparam int TP_W  = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
   localparam logic [CNT_W-1:0] LAST_PIX  = CNT_W'(PIXELS_PER_FRAME - 1);
   localparam logic [TP_W:0]    TAG_LIMIT = (TP_W + 1)'(TAG_DEPTH);

   logic [7:0]      bank0 [0:PIXELS_PER_FRAME-1];
   logic [7:0]      bank1 [0:PIXELS_PER_FRAME-1];
   logic [ID_W-1:0] bank_id [0:1];
   logic [1:0]      full;
   logic            w_bank;
   logic            r_bank;
   logic [CNT_W-1:0] cnt;
   logic [ID_W-1:0] next_id;

   logic [ID_W-1:0] tag_id [0:TAG_DEPTH-1];
   logic [TP_W-1:0] tag_wp;
   logic [TP_W-1:0] tag_rp;
   logic [TP_W:0]   tag_cnt;
   logic            tag_full;
   logic            tag_empty;

   logic pix_accept;
   logic frame_done;
   logic avail;
   logic release_fr;
   logic cls_take;
   logic tag_pop;
   logic res_fire;
   logic unused_wdata;

   // Only bit0 of the input-valid write carries meaning.
   assign unused_wdata = ^cls_input_valid_write_data[7:1];

   assign tag_full   = (tag_cnt == TAG_LIMIT);
   assign tag_empty  = (tag_cnt == '0);
   assign pix_ready  = !reset && !full[w_bank];
   assign pix_accept = pix_valid && pix_ready;
   assign frame_done = pix_accept && (cnt == LAST_PIX);
   // A frame is offered only while there is room to tag it, so releases never overflow the tag FIFO.
   assign avail      = full[r_bank] && !tag_full;
   assign release_fr = cls_input_valid_write_en && !cls_input_valid_write_data[0] && avail;
   assign res_fire   = res_valid && res_ready;
   assign cls_output_ready = res_ready || !res_valid;
   assign cls_take   = cls_output_valid && cls_output_ready;
   assign tag_pop    = cls_take && !tag_empty;
   assign cls_input_valid_read_data = {7'b0, avail};

   // Pixel storage into the current write bank; contents survive reset.
   always_ff @(posedge clk) begin
      if (pix_accept) begin
         if (w_bank) bank1[cnt] <= pix_data;
         else        bank0[cnt] <= pix_data;
      end
   end

   // Registered classifier read port from the current read bank.
   always_ff @(posedge clk) begin
      if (reset) cls_input_read_data_a <= 16'h0000;
      else       cls_input_read_data_a <= {8'h00, r_bank ? bank1[cls_input_address_a]
                                                         : bank0[cls_input_address_a]};
   end

   // Bank ownership: write-complete fills W and advances it, release empties R and advances it.
   always_ff @(posedge clk) begin
      if (reset) begin
         full    <= 2'b00;
         w_bank  <= 1'b0;
         r_bank  <= 1'b0;
         cnt     <= '0;
         next_id <= '0;
      end else begin
         if (pix_accept) cnt <= frame_done ? '0 : cnt + CNT_W'(1);
         if (frame_done) begin
            full[w_bank] <= 1'b1;
            next_id      <= next_id + ID_W'(1);
            w_bank       <= !w_bank;
         end
         if (release_fr) begin
            full[r_bank] <= 1'b0;
            r_bank       <= !r_bank;
         end
      end
   end

   // Frame IDs follow their bank; tag payload is captured at release.
   always_ff @(posedge clk) begin
      if (frame_done) bank_id[w_bank] <= next_id;
      if (release_fr) tag_id[tag_wp] <= bank_id[r_bank];
   end

   // Tag FIFO pointers and occupancy; simultaneous push and pop leave occupancy unchanged.
   always_ff @(posedge clk) begin
      if (reset) begin
         tag_wp  <= '0;
         tag_rp  <= '0;
         tag_cnt <= '0;
      end else begin
         if (release_fr) tag_wp <= tag_wp + TP_W'(1);
         if (tag_pop)    tag_rp <= tag_rp + TP_W'(1);
         if (release_fr && !tag_pop)      tag_cnt <= tag_cnt + (TP_W + 1)'(1);
         else if (!release_fr && tag_pop) tag_cnt <= tag_cnt - (TP_W + 1)'(1);
      end
   end

   // One-entry result register; a classifier result with no tag is dropped and flagged.
   always_ff @(posedge clk) begin
      if (reset) begin
         res_valid     <= 1'b0;
         res_digit     <= 4'h0;
         res_frame_id  <= '0;
         frames_done   <= 16'h0000;
         tag_underflow <= 1'b0;
      end else begin
         if (tag_pop) begin
            res_valid    <= 1'b1;
            res_digit    <= cls_output_data;
            res_frame_id <= tag_id[tag_rp];
         end else if (res_fire) begin
            res_valid <= 1'b0;
         end
         if (cls_take && tag_empty) tag_underflow <= 1'b1;
         if (res_fire) frames_done <= frames_done + 16'd1;
      end
   end

`ifdef CLS_LATENCY_STATS_EN
   logic [31:0] cycle_cnt;
   logic [15:0] tag_stamp [0:TAG_DEPTH-1];
   logic [15:0] lat_q;

   // Release-time stamp stored alongside the frame ID.
   always_ff @(posedge clk) begin
      if (release_fr) tag_stamp[tag_wp] <= cycle_cnt[15:0];
   end

   // Free-running cycle counter and latency capture at result load.
   always_ff @(posedge clk) begin
      if (reset) begin
         cycle_cnt <= 32'h0;
         lat_q     <= 16'h0;
      end else begin
         cycle_cnt <= cycle_cnt + 32'd1;
         if (tag_pop) lat_q <= cycle_cnt[15:0] - tag_stamp[tag_rp];
      end
   end

   assign res_latency = lat_q;
`else
   assign res_latency = 16'h0000;
`endif

endmodule

// File: doc/classifier_frame_scheduler.md
Name: classifier_frame_scheduler

Overview:
Sequences image frames into the ClassifierPipeline accelerator. Accepts a byte-wide pixel stream into an internal ping-pong pair of frame banks. Serves the accelerator's input-valid flag and input RAM port from the current read bank. Tags each classification result with its frame ID before handing it downstream. Sits between the pixel source (camera/DMA) and ClassifierPipeline_top.

Parameters:
PIXELS_PER_FRAME, 784, pixels per frame; bank depth.
ADDR_W, 10, classifier input address width; must satisfy 2^ADDR_W >= PIXELS_PER_FRAME.
ID_W, 8, frame ID width; wraps modulo 2^ID_W.
TAG_DEPTH, 4, frames consumed by the classifier but not yet reported; power of 2.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
pix_data  in  8  pixel byte
pix_valid  in  1  pixel valid
pix_ready  out  1  pixel accepted when pix_valid&pix_ready
cls_input_valid_write_en  in  1  classifier writes its input-valid flag
cls_input_valid_write_data  in  8  value written; bit0 significant
cls_input_valid_read_data  out  8  {7'b0, frame available}
cls_input_address_a  in  ADDR_W  classifier pixel read address
cls_input_read_data_a  out  16  {8'b0, pixel}, registered
cls_output_data  in  4  predicted digit from classifier
cls_output_valid  in  1  classifier result valid
cls_output_ready  out  1  result accepted by scheduler
res_digit  out  4  tagged predicted digit
res_frame_id  out  ID_W  frame ID of result
res_latency  out  16  cycles from frame release to result (see Optional Feature)
res_valid  out  1  result valid
res_ready  in  1  downstream accepts result
frames_done  out  16  count of results handed off; wraps
tag_underflow  out  1  sticky error flag

Behaviour:
- Clock is clk; reset is synchronous and active-high.
- Reset values:
  - pix_ready=0 during reset, 1 on the first cycle after reset.
  - cls_input_valid_read_data=0; cls_input_read_data_a=0.
  - res_valid=0; res_digit=0; res_frame_id=0; res_latency=0.
  - frames_done=0; tag_underflow=0.
  - Internal state: both banks empty; write bank W=0; read bank R=0; pixel counter=0; next ID=0; tag FIFO empty.
- Reset mid-operation discards partial and full frames. Bank RAM contents are not cleared.
- Write side:
  - pix_ready = !full[W].
  - On each accepted pixel, bank[W][cnt] <= pix_data and cnt increments.
  - At cnt == PIXELS_PER_FRAME-1, on the accept: full[W] set, ID[W] <= next ID, next ID increments, cnt cleared.
  - W toggles on that same edge, so pix_ready follows the new bank's full flag next cycle.
- Read side:
  - cls_input_valid_read_data[0] = full[R] && !tag_full. Combinational.
  - cls_input_read_data_a <= {8'b0, bank[R][cls_input_address_a]} every cycle. One-cycle latency.
  - Out-of-range addresses return undefined data.
- Frame release:
  - Occurs when cls_input_valid_write_en=1, write_data[0]=0, and full[R]=1.
  - Same edge: clear full[R], push {ID[R], cycle stamp} into tag FIFO, toggle R.
  - A write with data[0]=1, or any write when full[R]=0, is ignored.
- Simultaneous write-complete and release on different banks: both take effect on the same edge. Write-complete and release never target the same bank, because W advances only past a bank whose flag is empty.
- Result side:
  - cls_output_ready = res_ready || !res_valid (one-entry output register).
  - On cls_output_valid && cls_output_ready with tag FIFO non-empty: pop a tag, load res_digit/res_frame_id/res_latency, set res_valid.
  - If the tag FIFO is empty at that point: tag_underflow <= 1 (sticky until reset); the result is dropped.
  - res_valid clears on res_valid && res_ready unless reloaded in the same cycle.
  - frames_done increments on each res handshake.
- Tag FIFO:
  - TAG_DEPTH entries.
  - tag_full gates frame availability, so no further releases occur while full.
  - Push and pop in the same cycle are allowed; occupancy is unchanged.

Optional Feature:
CLS_LATENCY_STATS_EN
- Defined:
  - Free-running 32-bit cycle counter; its low 16 bits are stored in the tag at release.
  - res_latency = (counter at result load) − stamp, 16-bit wrap.
- Undefined: no counter and no stamp storage; res_latency tied to 0.

Test Plan:
- Reset, stream 784 pixels of frame A (value = addr[7:0]), classifier reads address 5 → read_data_a=16'h0005 one cycle later; read_data bit0=1.
- Stream 3 frames back-to-back with no classifier release → pix_ready drops after pixel 1568. After release (write_data=0), pix_ready=1 next cycle, R toggles, third frame accepted.
- Classifier writes input_valid=1 → no state change. Writes 0 → release, tag ID 0 pushed. Output digit 7 → res_digit=7, res_frame_id=0, frames_done=1 after res_ready.
- res_ready held 0 with two results pending → cls_output_ready=0 after first load. Results emerge in order with IDs 0,1.
- Fill TAG_DEPTH=4 releases without results → read_data bit0=0 despite a full bank. One result popped → bit0 returns to 1.
- cls_output_valid with empty tag FIFO → tag_underflow=1 and stays 1. Reset asserted mid-frame (pixel 300) → pix_ready=1 after reset, next frame gets ID 0.
